arm_instr_encoder: RTL and testbench

//  Pipelined ARM machine-code encoder: the inverse of the control-unit decoder.

---
 rtl/arm_instr_encoder.sv | 164 ++++++++++++++++
 tb/tb_arm_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_instr_encoder.sv
// Two-stage ARM encoder: S1 holds field bundle + legality, S2 holds the encoded word.
// Optional feature: define ENC_CHECKSUM_EN to build a running XOR of emitted words.
module arm_instr_encoder #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_class,
  input  logic [2:0]        alu_op,
  input  logic [3:0]        cond,
  input  logic              s_bit,
  input  logic [3:0]        rd,
  input  logic [3:0]        rn,
  input  logic [3:0]        rm,
  input  logic [11:0]       imm12,
  input  logic [23:0]       imm24,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err,
  input  logic              err_clr,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    CLS_DP_IMM = 3'd0,
    CLS_DP_REG = 3'd1,
    CLS_LDR    = 3'd2,
    CLS_STR    = 3'd3,
    CLS_B      = 3'd4,
    CLS_BL     = 3'd5
  } op_class_e;

  typedef struct packed {
    logic [2:0]  op_class;
    logic [2:0]  alu_op;
    logic [3:0]  cond;
    logic        s_bit;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [11:0] imm12;
    logic [23:0] imm24;
  } fields_t;

  fields_t     s1;
  logic        s1_full;
  logic        s1_legal;
  logic        legal_in;
  logic        in_fire;
  logic        out_fire;
  logic        s1_adv;
  logic [31:0] enc;
  logic [3:0]  cmd;
  logic [3:0]  rn_eff;
  logic        is_dp;

  assign legal_in = (op_class <= 3'd5) &&
                    !((op_class <= 3'd1) && (alu_op >= 3'd5));

  // An illegal bundle in S1 is simply dropped, so it never waits on S2.
  assign s1_adv   = s1_full && (!instr_valid || instr_ready || !s1_legal);
  assign in_ready = !s1_full || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = instr_valid && instr_ready;

  always_comb begin
    cmd    = 4'b0100;
    enc    = '0;
    is_dp  = (s1.op_class == CLS_DP_IMM) || (s1.op_class == CLS_DP_REG);
    rn_eff = s1.rn;
    case (s1.alu_op)
      3'b000:  cmd = 4'b0100;
      3'b001:  cmd = 4'b0010;
      3'b010:  cmd = 4'b0000;
      3'b011:  cmd = 4'b1100;
      3'b100:  begin
        cmd    = 4'b1101;
        rn_eff = 4'd0;
      end
      default: cmd = 4'b0100;
    endcase
    if (is_dp) begin
      enc = {s1.cond, 2'b00, (s1.op_class == CLS_DP_IMM), cmd, s1.s_bit, rn_eff, s1.rd,
             (s1.op_class == CLS_DP_IMM) ? s1.imm12 : {8'b0, s1.rm}};
    end else begin
      case (s1.op_class)
        CLS_LDR: enc = {s1.cond, 2'b01, 6'b011001, s1.rn, s1.rd, s1.imm12};
        CLS_STR: enc = {s1.cond, 2'b01, 6'b011000, s1.rn, s1.rd, s1.imm12};
        CLS_B:   enc = {s1.cond, 2'b10, 2'b10, s1.imm24};
        CLS_BL:  enc = {s1.cond, 2'b10, 2'b11, s1.imm24};
        default: enc = '0;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; s1_full alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1 <= '{op_class, alu_op, cond, s_bit, rd, rn, rm, imm12, imm24};
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_full  <= 1'b0;
      s1_legal <= 1'b0;
    end else if (in_fire) begin
      s1_full  <= 1'b1;
      s1_legal <= legal_in;
    end else if (s1_adv) begin
      s1_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_addr  <= BASE_ADDR;
    end else begin
      if (out_fire) begin
        instr_addr <= instr_addr + ADDR_W'(4);
      end
      if (s1_adv && s1_legal) begin
        instr_valid <= 1'b1;
        instr       <= enc;
      end else if (out_fire) begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Setting has priority over err_clr so a same-cycle illegal bundle is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (in_fire && !legal_in) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] checksum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (out_fire) begin
      checksum_q <= checksum_q ^ instr;
    end
  end
  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Bench for arm_instr_encoder: directed spec vectors plus random traffic against a scoreboard.
`timescale 1ns/1ps
module tb_arm_instr_encoder;

  typedef struct {
    logic [2:0]  op_class;
    logic [2:0]  alu_op;
    logic [3:0]  cond;
    logic        s_bit;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [11:0] imm12;
    logic [23:0] imm24;
  } bundle_t;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op_class = '0;
  logic [2:0]  alu_op = '0;
  logic [3:0]  cond = '0;
  logic        s_bit = 1'b0;
  logic [3:0]  rd = '0;
  logic [3:0]  rn = '0;
  logic [3:0]  rm = '0;
  logic [11:0] imm12 = '0;
  logic [23:0] imm24 = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        err;
  logic        err_clr = 1'b0;
  logic [31:0] checksum;

  arm_instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .alu_op(alu_op), .cond(cond), .s_bit(s_bit),
    .rd(rd), .rn(rn), .rm(rm), .imm12(imm12), .imm24(imm24),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_addr(instr_addr), .err(err), .err_clr(err_clr), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  item_t       q[$];
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_xor  = 32'h0;
  logic        err_exp  = 1'b0;
  int          cyc      = 0;
  int          xfer_cnt = 0;
  logic        acc;
  logic        last_in_ready;
  logic        use_lit   = 1'b0;
  logic [31:0] lit_word  = '0;
  logic        check_lat = 1'b0;
  bundle_t     idle_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bundle_t mk(input int cls, input int alu, input int cnd, input int s,
                                 input int d, input int n, input int m, input int i12, input int i24);
    bundle_t b;
    b.op_class = 3'(cls); b.alu_op = 3'(alu); b.cond = 4'(cnd); b.s_bit = 1'(s);
    b.rd = 4'(d); b.rn = 4'(n); b.rm = 4'(m); b.imm12 = 12'(i12); b.imm24 = 24'(i24);
    return b;
  endfunction

  function automatic bit is_legal(input bundle_t b);
    return (b.op_class < 6) && !((b.op_class < 2) && (b.alu_op > 4));
  endfunction

  // Reference encoder, built field-by-field with shifts and sums.
  function automatic logic [31:0] ref_word(input bundle_t b);
    int unsigned cmd_tab[5] = '{4, 2, 0, 12, 13};
    int unsigned w = int'(b.cond) << 28;
    case (b.op_class)
      0, 1: begin
        w += (b.op_class == 0 ? 1 : 0) << 25;
        w += cmd_tab[b.alu_op] << 21;
        w += int'(b.s_bit) << 20;
        w += (b.alu_op == 4 ? 0 : int'(b.rn)) << 16;
        w += int'(b.rd) << 12;
        w += (b.op_class == 0) ? int'(b.imm12) : int'(b.rm);
      end
      2, 3: begin
        w += 1 << 26;
        w += (b.op_class == 2 ? 25 : 24) << 20;
        w += (int'(b.rn) << 16) + (int'(b.rd) << 12) + int'(b.imm12);
      end
      default: begin
        w += 2 << 26;
        w += (b.op_class == 4 ? 2 : 3) << 24;
        w += int'(b.imm24);
      end
    endcase
    return w;
  endfunction

  task automatic cycle(input bundle_t b, input logic v, input logic ir, input logic clr);
    item_t e;
    @(negedge clk);
    op_class = b.op_class; alu_op = b.alu_op; cond = b.cond; s_bit = b.s_bit;
    rd = b.rd; rn = b.rn; rm = b.rm; imm12 = b.imm12; imm24 = b.imm24;
    in_valid = v; instr_ready = ir; err_clr = clr;
    #1;
    check("err", {63'd0, err}, {63'd0, err_exp});
`ifdef ENC_CHECKSUM_EN
    check("checksum", {32'd0, checksum}, {32'd0, exp_xor});
`else
    check("checksum", {32'd0, checksum}, 64'd0);
`endif
    last_in_ready = in_ready;
    if (instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        check("spurious_word", {32'd0, instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("instr", {32'd0, instr}, {32'd0, e.word});
        check("addr", {32'd0, instr_addr}, {32'd0, exp_addr});
        if (check_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
        exp_xor ^= e.word;
      end
      exp_addr += 32'd4;
      xfer_cnt++;
    end
    acc = v && in_ready;
    if (acc && is_legal(b)) begin
      e.word = use_lit ? lit_word : ref_word(b);
      e.cyc  = cyc;
      q.push_back(e);
    end
    if (acc && !is_legal(b)) err_exp = 1'b1;
    else if (clr)            err_exp = 1'b0;
    cyc++;
  endtask

  task automatic send(input bundle_t b, input logic [31:0] w, input logic ir);
    use_lit = 1'b1; lit_word = w;
    for (int i = 0; i < 20; i++) begin
      cycle(b, 1'b1, ir, 1'b0);
      if (acc) break;
    end
    check("send_accepted", {63'd0, acc}, 64'd1);
    use_lit = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle(idle_b, 1'b0, 1'b1, 1'b0);
    cycle(idle_b, 1'b0, 1'b1, 1'b0);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic reset_model();
    q.delete();
    exp_addr = 32'h0; exp_xor = 32'h0; err_exp = 1'b0;
  endtask

  initial begin
    int base;
    bundle_t add_b, sub_b, ldr_b, bad_b, rb;
    idle_b = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_b  = mk(0, 0, 14, 0, 1, 2, 0, 5, 0);
    sub_b  = mk(1, 1, 14, 1, 3, 3, 4, 0, 0);
    ldr_b  = mk(2, 0, 14, 0, 0, 1, 0, 8, 0);
    bad_b  = mk(7, 0, 14, 0, 1, 2, 0, 5, 0);

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_addr", {32'd0, instr_addr}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors with the output side always ready.
    check_lat = 1'b1;
    send(add_b, 32'hE282_1005, 1'b1);
    drain();
    send(sub_b, 32'hE053_3004, 1'b1);
    send(mk(1, 4, 14, 0, 5, 9, 6, 0, 0), 32'hE1A0_5006, 1'b1);
    send(ldr_b, 32'hE591_0008, 1'b1);
    send(mk(3, 0, 14, 0, 0, 1, 0, 8, 0), 32'hE581_0008, 1'b1);
    send(mk(4, 0, 14, 0, 0, 0, 0, 0, 16), 32'hEA00_0010, 1'b1);
    send(mk(5, 0, 14, 0, 0, 0, 0, 0, 16), 32'hEB00_0010, 1'b1);
    drain();
    check_lat = 1'b0;

    // Backpressure: two words fill the pipe, the third must wait.
    send(add_b, 32'hE282_1005, 1'b0);
    send(sub_b, 32'hE053_3004, 1'b0);
    use_lit = 1'b1; lit_word = 32'hE591_0008;
    cycle(ldr_b, 1'b1, 1'b0, 1'b0);
    check("bp_in_ready", {63'd0, last_in_ready}, 64'd0);
    cycle(ldr_b, 1'b1, 1'b0, 1'b0);
    cycle(ldr_b, 1'b1, 1'b0, 1'b0);
    check("bp_in_ready_hold", {63'd0, last_in_ready}, 64'd0);
    base = xfer_cnt;
    cycle(ldr_b, 1'b1, 1'b1, 1'b0);
    check("bp_third_accepted", {63'd0, acc}, 64'd1);
    use_lit = 1'b0;
    cycle(idle_b, 1'b0, 1'b1, 1'b0);
    cycle(idle_b, 1'b0, 1'b1, 1'b0);
    check("bp_rate", 64'(xfer_cnt - base), 64'd3);
    drain();

    // Illegal bundle between two ADDs; then clear, then set-wins-over-clear.
    send(add_b, 32'hE282_1005, 1'b1);
    send(bad_b, 32'h0, 1'b1);
    send(add_b, 32'hE282_1005, 1'b1);
    drain();
    check("err_set", {63'd0, err}, 64'd1);
    cycle(idle_b, 1'b0, 1'b1, 1'b1);
    cycle(idle_b, 1'b0, 1'b1, 1'b0);
    check("err_cleared", {63'd0, err}, 64'd0);
    cycle(mk(1, 6, 14, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b1);
    cycle(idle_b, 1'b0, 1'b1, 1'b0);
    check("err_set_wins", {63'd0, err}, 64'd1);
    cycle(idle_b, 1'b0, 1'b1, 1'b1);

    // Random traffic with random backpressure and occasional illegal bundles.
    for (int i = 0; i < 600; i++) begin
      rb = mk(($urandom_range(0, 11) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5),
              ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
              $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 4095),
              $urandom_range(0, 24'hFF_FFFF));
      cycle(rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end
    drain();

    // Asynchronous reset while S2 holds a stalled word.
    send(add_b, 32'hE282_1005, 1'b0);
    cycle(idle_b, 1'b0, 1'b0, 1'b0);
    cycle(idle_b, 1'b0, 1'b0, 1'b0);
    check("pre_reset_valid", {63'd0, instr_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_valid_now", {63'd0, instr_valid}, 64'd0);
    check("reset_addr", {32'd0, instr_addr}, 64'd0);
    check("reset_checksum", {32'd0, checksum}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    cycle(idle_b, 1'b0, 1'b1, 1'b0);
    check("post_reset_no_word", {63'd0, instr_valid}, 64'd0);
    send(ldr_b, 32'hE591_0008, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
